// File: rtl/seq_detect_stream_ctrl.sv
// rtl/seq_detect_stream_ctrl.sv - word-to-serial sequencer and match counter for a "1010" detector
// Gates the detector reset so idle gaps never feed it bits.
module seq_detect_stream_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [CNT_W-1:0]  threshold,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              det_x,
  output logic              det_rst_n,
  input  logic              det_z,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [IDX_W-1:0]  bit_idx, bit_idx_nxt;
  logic              accept;
  logic              count_en;
  logic              done_hit;
  logic [CNT_W-1:0]  cnt_inc;

  // rst_n term keeps in_ready low while reset is held, independent of enable
  assign in_ready = rst_n & enable & ~done &
                    ((state == IDLE) | ((state == SHIFT) & (bit_idx == '0)));
  assign accept   = in_valid & in_ready;
  assign det_x    = (state == SHIFT) ? shreg[DATA_W-1] : 1'b0;
  assign busy     = (state == SHIFT) | (state == DRAIN);

  assign count_en = busy & det_z;
  assign cnt_inc  = (match_cnt == CNT_MAX) ? match_cnt : match_cnt + 1'b1;
  assign done_hit = count_en & (threshold != '0) & (cnt_inc >= threshold);

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_idx_nxt = bit_idx;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt   = SHIFT;
          shreg_nxt   = in_data;
          bit_idx_nxt = LAST_IDX;
        end
      end
      SHIFT: begin
        if (bit_idx != '0) begin
          shreg_nxt   = {shreg[DATA_W-2:0], 1'b0};
          bit_idx_nxt = bit_idx - 1'b1;
        end else if (accept) begin
          shreg_nxt   = in_data;
          bit_idx_nxt = LAST_IDX;
        end else begin
          state_nxt = DRAIN;
        end
      end
      DRAIN:   state_nxt = (done | done_hit) ? DONE : IDLE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      det_rst_n <= 1'b0;
      match_cnt <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      bit_idx   <= bit_idx_nxt;
      det_rst_n <= (state_nxt == SHIFT) | (state_nxt == DRAIN);
      if (clear) begin
        match_cnt <= '0;
        done      <= 1'b0;
      end else begin
        if (count_en) match_cnt <= cnt_inc;
        if (done_hit) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_stream_ctrl.sv
// tb/tb_seq_detect_stream_ctrl.sv - directed bench for seq_detect_stream_ctrl with a behavioural 1010 detector
module tb_seq_detect_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, enable, clear;
  logic [7:0] threshold, in_data;
  logic       valid_a, valid_b;
  logic       in_ready_a, det_x_a, det_rst_n_a, det_z_a, busy_a, done_a;
  logic       in_ready_b, det_x_b, det_rst_n_b, det_z_b, busy_b, done_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [2:0] st_a, st_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_detect_stream_ctrl #(.DATA_W(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .threshold(threshold),
    .in_data(in_data), .in_valid(valid_a), .in_ready(in_ready_a), .det_x(det_x_a),
    .det_rst_n(det_rst_n_a), .det_z(det_z_a), .match_cnt(cnt_a), .busy(busy_a), .done(done_a)
  );

  seq_detect_stream_ctrl #(.DATA_W(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .threshold(threshold[1:0]),
    .in_data(in_data), .in_valid(valid_b), .in_ready(in_ready_b), .det_x(det_x_b),
    .det_rst_n(det_rst_n_b), .det_z(det_z_b), .match_cnt(cnt_b), .busy(busy_b), .done(done_b)
  );

  // Overlapping Moore 1010 detector: 0 none, 1 "1", 2 "10", 3 "101", 4 "1010"
  function automatic logic [2:0] det_next(input logic [2:0] s, input logic x);
    case (s)
      3'd0:    det_next = x ? 3'd1 : 3'd0;
      3'd1:    det_next = x ? 3'd1 : 3'd2;
      3'd2:    det_next = x ? 3'd3 : 3'd0;
      3'd3:    det_next = x ? 3'd1 : 3'd4;
      default: det_next = x ? 3'd3 : 3'd0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge det_rst_n_a)
    if (!det_rst_n_a) st_a <= 3'd0; else st_a <= det_next(st_a, det_x_a);
  always_ff @(posedge clk or negedge det_rst_n_b)
    if (!det_rst_n_b) st_b <= 3'd0; else st_b <= det_next(st_b, det_x_b);
  assign det_z_a = (st_a == 3'd4);
  assign det_z_b = (st_b == 3'd4);

  typedef struct {
    logic [7:0] w0;
    logic [7:0] w1;
    int         nwords;
    bit         gap;
    logic [7:0] thr;
    logic [7:0] exp_cnt;
    bit         exp_done;
    bit         exp_acc1;
  } row_t;

  row_t rows[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following the accept edge.
  task automatic offer(input bit sel, input logic [7:0] w, input int max_cyc, output bit acc);
    acc = 1'b0;
    in_data = w;
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      if (sel ? in_ready_b : in_ready_a) begin
        acc = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input bit sel);
    for (int i = 0; i < 40; i++) begin
      if (!(sel ? busy_b : busy_a)) break;
      @(negedge clk);
    end
    check("idle_timeout", 32'(sel ? busy_b : busy_a), 32'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    bit         acc;
    logic [7:0] w;

    rows[0] = '{8'h0A, 8'h00, 1, 1'b0, 8'd0, 8'd1, 1'b0, 1'b0};
    rows[1] = '{8'hAA, 8'h00, 1, 1'b0, 8'd0, 8'd3, 1'b0, 1'b0};
    rows[2] = '{8'h05, 8'h00, 2, 1'b0, 8'd0, 8'd1, 1'b0, 1'b1};
    rows[3] = '{8'h05, 8'h00, 2, 1'b1, 8'd0, 8'd0, 1'b0, 1'b1};
    rows[4] = '{8'hAA, 8'hAA, 2, 1'b0, 8'd2, 8'd3, 1'b1, 1'b0};
    rows[5] = '{8'h0A, 8'h00, 1, 1'b0, 8'd1, 8'd1, 1'b1, 1'b0};
    rows[6] = '{8'hAA, 8'h0A, 2, 1'b0, 8'd0, 8'd4, 1'b0, 1'b1};
    rows[7] = '{8'h50, 8'h00, 1, 1'b0, 8'd0, 8'd1, 1'b0, 1'b0};
    rows[8] = '{8'hFF, 8'h00, 1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0};
    rows[9] = '{8'hAA, 8'hAA, 2, 1'b0, 8'd5, 8'd7, 1'b1, 1'b1};

    rst_n = 1'b0; enable = 1'b1; clear = 1'b0; threshold = 8'd0;
    in_data = 8'h00; valid_a = 1'b0; valid_b = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_det_x", 32'(det_x_a), 32'd0);
    check("rst_det_rst_n", 32'(det_rst_n_a), 32'd0);
    check("rst_cnt", 32'(cnt_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Serial order and z timing for a single 0x0A
    w = 8'h0A;
    offer(1'b0, w, 4, acc);
    valid_a = 1'b0;
    check("t1_accept", 32'(acc), 32'd1);
    for (int b = 7; b >= 0; b--) begin
      check($sformatf("t1_det_x_bit%0d", b), 32'(det_x_a), 32'(w[b]));
      check($sformatf("t1_det_z_bit%0d", b), 32'(det_z_a), 32'd0);
      @(negedge clk);
    end
    check("t1_drain_busy", 32'(busy_a), 32'd1);
    check("t1_drain_z", 32'(det_z_a), 32'd1);
    check("t1_drain_x", 32'(det_x_a), 32'd0);
    @(negedge clk);
    check("t1_idle_busy", 32'(busy_a), 32'd0);
    check("t1_cnt", 32'(cnt_a), 32'd1);
    check("t1_done", 32'(done_a), 32'd0);
    check("t1_det_rst_n", 32'(det_rst_n_a), 32'd0);

    for (int r = 0; r < 10; r++) begin
      threshold = rows[r].thr;
      do_clear();
      offer(1'b0, rows[r].w0, 4, acc);
      check($sformatf("row%0d_acc0", r), 32'(acc), 32'd1);
      if (rows[r].gap) begin
        valid_a = 1'b0;
        wait_idle(1'b0);
        check($sformatf("row%0d_gap_det_rst_n", r), 32'(det_rst_n_a), 32'd0);
      end
      if (rows[r].nwords == 2) begin
        offer(1'b0, rows[r].w1, 15, acc);
        check($sformatf("row%0d_acc1", r), 32'(acc), 32'(rows[r].exp_acc1));
      end
      valid_a = 1'b0;
      wait_idle(1'b0);
      check($sformatf("row%0d_cnt", r), 32'(cnt_a), 32'(rows[r].exp_cnt));
      check($sformatf("row%0d_done", r), 32'(done_a), 32'(rows[r].exp_done));
      check($sformatf("row%0d_in_ready", r), 32'(in_ready_a), 32'(!rows[r].exp_done));
    end

    // clear mid-word drops the word and the count
    threshold = 8'd0;
    do_clear();
    offer(1'b0, 8'hAA, 4, acc);
    valid_a = 1'b0;
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_cnt", 32'(cnt_a), 32'd0);
    check("clr_busy", 32'(busy_a), 32'd0);
    check("clr_det_rst_n", 32'(det_rst_n_a), 32'd0);
    check("clr_in_ready", 32'(in_ready_a), 32'd1);

    // clear beats a same-cycle accept
    in_data = 8'hAA; valid_a = 1'b1; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; valid_a = 1'b0;
    check("clr_vs_accept_busy", 32'(busy_a), 32'd0);

    // enable dropped mid-word: word still completes
    offer(1'b0, 8'h0A, 4, acc);
    valid_a = 1'b0;
    enable = 1'b0;
    wait_idle(1'b0);
    check("en_low_cnt", 32'(cnt_a), 32'd1);
    check("en_low_in_ready", 32'(in_ready_a), 32'd0);
    valid_a = 1'b1;
    repeat (3) @(negedge clk);
    check("en_low_no_accept", 32'(busy_a), 32'd0);
    valid_a = 1'b0;
    enable = 1'b1;

    // 2-bit counter saturates over four back-to-back 0xAA words
    for (int k = 0; k < 4; k++) begin
      offer(1'b1, 8'hAA, 12, acc);
      check($sformatf("sat_acc%0d", k), 32'(acc), 32'd1);
    end
    valid_b = 1'b0;
    wait_idle(1'b1);
    check("sat_cnt", 32'(cnt_b), 32'd3);
    check("sat_done", 32'(done_b), 32'd0);

    // async reset mid-word
    offer(1'b1, 8'hAA, 4, acc);
    repeat (2) @(negedge clk);
    check("pre_rst_busy", 32'(busy_b), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy_b), 32'd0);
    check("arst_cnt", 32'(cnt_b), 32'd0);
    check("arst_det_rst_n", 32'(det_rst_n_b), 32'd0);
    check("arst_det_x", 32'(det_x_b), 32'd0);
    check("arst_in_ready", 32'(in_ready_b), 32'd0);
    check("arst_done", 32'(done_b), 32'd0);
    valid_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
